// File: rtl/doppler_fifo_pkg.sv
// Shared constants and helpers for the Doppler sample FIFO.
//   MODE_STREAM / MODE_REPLAY : values of the mode input
//   clog2                     : ceiling log2, used to check the FIFO parameters
package doppler_fifo_pkg;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_REPLAY = 1'b1;

  // Ceiling log2. Returns 0 for inputs 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port sample memory: synchronous write, registered synchronous read.
//   clk, reset        : clock, async active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates on the following edge
//   rd_data           : registered read data, holds when rd_en is low
module fifo_sdp_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/doppler_sample_fifo.sv
// Single-clock sample buffer with stream (consuming) and replay (retaining) modes.
//   clk, reset   : clock, async active-high reset
//   clear        : synchronous flush of pointers, count and sticky flags
//   mode         : 0 stream, 1 replay
//   rewind       : replay only, restart reading at the retained frame start
//   wr_en/data   : write port
//   rd_en        : read request; rd_data/rd_valid follow one cycle later
//   full, empty, almost_full, count : status derived from registered pointers
//   overrun, underrun               : sticky error flags
module doppler_sample_fifo
  import doppler_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_THRESH  = (1 << DEPTH_LOG2) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  rewind,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 1 || clog2(DEPTH) != DEPTH_LOG2 || AF_THRESH > DEPTH) begin : g_param_check
    $error("doppler_sample_fifo: illegal DEPTH_LOG2/AF_THRESH");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] base_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic          rewind_ok;
  logic          rd_ok;
  logic          wr_ok;

  // Status from registered pointers; wrap bit disambiguates full from empty.
  assign count       = wr_ptr - base_ptr;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (rd_ptr == wr_ptr);
  assign almost_full = (count >= PW'(AF_THRESH));

  // Accept logic: clear beats rewind beats read; write only blocked by clear/full.
  assign rewind_ok = rewind && (mode == MODE_REPLAY) && !clear;
  assign rd_ok     = rd_en && !empty && !rewind_ok && !clear;
  assign wr_ok     = wr_en && !full && !clear;

  // Next read pointer, also what base tracks while streaming.
  always_comb begin
    rd_ptr_next = rd_ptr;
    if (rewind_ok)  rd_ptr_next = base_ptr;
    else if (rd_ok) rd_ptr_next = rd_ptr + PW'(1);
  end

  // Pointer, valid and sticky flag registers. Tracking base in every stream
  // cycle also covers the replay->stream transition (already-read words freed).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_next;
      if (mode == MODE_STREAM) base_ptr <= rd_ptr_next;
      rd_valid <= rd_ok;
      if (wr_en && full) overrun <= 1'b1;
      if (rd_en && empty && !rewind_ok) underrun <= 1'b1;
    end
  end

  fifo_sdp_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule
